// File: rtl/raster_scan_ctrl_if.sv
// Shared types and the triangle-in / pixel-out bundle of the raster scan controller.

package raster_scan_pkg;
  typedef logic [11:0]        color12_t;
  typedef logic signed [31:0] q16_16_t;
endpackage

interface raster_scan_ctrl_if #(
  parameter int CW             = 20,
  parameter int DENOM_INV_BITS = 36,
  parameter int XW             = 9,
  parameter int YW             = 8
);
  import raster_scan_pkg::*;

  // triangle set-up side
  logic                             tri_valid;
  logic                             tri_ready;
  logic signed [CW-1:0]             tri_v0x;
  logic signed [CW-1:0]             tri_v0y;
  logic signed [CW-1:0]             tri_v1x;
  logic signed [CW-1:0]             tri_v1y;
  logic signed [CW-1:0]             tri_v2x;
  logic signed [CW-1:0]             tri_v2y;
  logic signed [DENOM_INV_BITS-1:0] tri_denom_inv;
  color12_t                         tri_c0;
  color12_t                         tri_c1;
  color12_t                         tri_c2;
  q16_16_t                          tri_d0;
  q16_16_t                          tri_d1;
  q16_16_t                          tri_d2;

  // pixel evaluator side
  logic [XW-1:0]                    pix_x;
  logic [YW-1:0]                    pix_y;
  logic signed [CW-1:0]             pix_v0x;
  logic signed [CW-1:0]             pix_v0y;
  logic signed [CW-1:0]             pix_e0x;
  logic signed [CW-1:0]             pix_e0y;
  logic signed [CW-1:0]             pix_e1x;
  logic signed [CW-1:0]             pix_e1y;
  logic signed [DENOM_INV_BITS-1:0] pix_denom_inv;
  color12_t                         pix_c0;
  color12_t                         pix_c1;
  color12_t                         pix_c2;
  q16_16_t                          pix_d0;
  q16_16_t                          pix_d1;
  q16_16_t                          pix_d2;
  logic                             pix_valid;
  logic                             pix_ready;
  logic                             eval_busy;

  // status
  logic                             tri_culled;
  logic                             busy;

  // master: the environment that supplies triangles and consumes pixels
  modport master (
    output tri_valid, tri_v0x, tri_v0y, tri_v1x, tri_v1y, tri_v2x, tri_v2y,
           tri_denom_inv, tri_c0, tri_c1, tri_c2, tri_d0, tri_d1, tri_d2,
           pix_ready, eval_busy,
    input  tri_ready, pix_x, pix_y, pix_v0x, pix_v0y, pix_e0x, pix_e0y,
           pix_e1x, pix_e1y, pix_denom_inv, pix_c0, pix_c1, pix_c2,
           pix_d0, pix_d1, pix_d2, pix_valid, tri_culled, busy
  );

  // slave: the scan controller itself
  modport slave (
    input  tri_valid, tri_v0x, tri_v0y, tri_v1x, tri_v1y, tri_v2x, tri_v2y,
           tri_denom_inv, tri_c0, tri_c1, tri_c2, tri_d0, tri_d1, tri_d2,
           pix_ready, eval_busy,
    output tri_ready, pix_x, pix_y, pix_v0x, pix_v0y, pix_e0x, pix_e0y,
           pix_e1x, pix_e1y, pix_denom_inv, pix_c0, pix_c1, pix_c2,
           pix_d0, pix_d1, pix_d2, pix_valid, tri_culled, busy
  );
endinterface

// File: rtl/raster_scan_ctrl.sv
// Triangle traversal: latches one triangle, derives edges and a clamped pixel
// bounding box, then streams every box pixel in raster order to pixel_eval.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for a triangle, tri_ready high
//   SETUP | one cycle: edge vectors, bbox, clamp and cull decision
//   SCAN  | presenting box pixels, x fastest, one per handshake

module raster_scan_ctrl #(
  parameter int WIDTH          = 320,
  parameter int HEIGHT         = 240,
  parameter int SUBPIXEL_BITS  = 4,
  parameter int DENOM_INV_BITS = 36
) (
  input  logic              clk,
  input  logic              rst,
  raster_scan_ctrl_if.slave bus
);
  import raster_scan_pkg::*;

  localparam int CW = 16 + SUBPIXEL_BITS;
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  localparam logic signed [CW-1:0] C_ZERO  = '0;
  localparam logic signed [CW-1:0] C_X_MAX = CW'(WIDTH - 1);
  localparam logic signed [CW-1:0] C_Y_MAX = CW'(HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SCAN  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // latched triangle; v0 and the attributes double as the pix_* output registers
  logic signed [CW-1:0]             r_v1x, r_v1y, r_v2x, r_v2y;
  logic signed [CW-1:0]             r_pix_v0x, r_pix_v0y;
  logic signed [CW-1:0]             r_pix_e0x, r_pix_e0y, r_pix_e1x, r_pix_e1y;
  logic signed [DENOM_INV_BITS-1:0] r_pix_denom_inv;
  color12_t                         r_pix_c0, r_pix_c1, r_pix_c2;
  q16_16_t                          r_pix_d0, r_pix_d1, r_pix_d2;

  // scan position and bounds
  logic [XW-1:0] r_pix_x, r_min_x, r_max_x;
  logic [YW-1:0] r_pix_y, r_max_y;
  logic          r_tri_culled;

  // set-up arithmetic
  logic signed [CW-1:0] w_min_vx, w_max_vx, w_min_vy, w_max_vy;
  logic signed [CW-1:0] w_min_px, w_max_px, w_min_py, w_max_py;
  logic [XW-1:0]        w_min_x, w_max_x;
  logic [YW-1:0]        w_min_y, w_max_y;
  logic                 w_cull;

  // FSM decodes
  logic w_accept, w_setup_go, w_setup_cull, w_x_step, w_y_step;

  function automatic logic signed [CW-1:0] f_min3(
    input logic signed [CW-1:0] a,
    input logic signed [CW-1:0] b,
    input logic signed [CW-1:0] c
  );
    logic signed [CW-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [CW-1:0] f_max3(
    input logic signed [CW-1:0] a,
    input logic signed [CW-1:0] b,
    input logic signed [CW-1:0] c
  );
    logic signed [CW-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Pixel bbox: floor via arithmetic shift, clamp to screen, cull when off-screen or degenerate.
  always_comb begin
    w_min_vx = f_min3(r_pix_v0x, r_v1x, r_v2x);
    w_max_vx = f_max3(r_pix_v0x, r_v1x, r_v2x);
    w_min_vy = f_min3(r_pix_v0y, r_v1y, r_v2y);
    w_max_vy = f_max3(r_pix_v0y, r_v1y, r_v2y);

    w_min_px = w_min_vx >>> SUBPIXEL_BITS;
    w_max_px = w_max_vx >>> SUBPIXEL_BITS;
    w_min_py = w_min_vy >>> SUBPIXEL_BITS;
    w_max_py = w_max_vy >>> SUBPIXEL_BITS;

    // low-side clamp of min and high-side clamp of max; the other sides are culled
    w_min_x = (w_min_px < C_ZERO)  ? '0              : w_min_px[XW-1:0];
    w_max_x = (w_max_px > C_X_MAX) ? XW'(WIDTH - 1)  : w_max_px[XW-1:0];
    w_min_y = (w_min_py < C_ZERO)  ? '0              : w_min_py[YW-1:0];
    w_max_y = (w_max_py > C_Y_MAX) ? YW'(HEIGHT - 1) : w_max_py[YW-1:0];

    w_cull = (r_pix_denom_inv == '0) ||
             (w_max_px < C_ZERO) || (w_max_py < C_ZERO) ||
             (w_min_px > C_X_MAX) || (w_min_py > C_Y_MAX);
  end

  // State register; reset aborts any scan in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state and per-cycle control decodes.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_setup_go   = 1'b0;
    w_setup_cull = 1'b0;
    w_x_step     = 1'b0;
    w_y_step     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.tri_valid) begin
          w_accept     = 1'b1;
          w_next_state = SETUP;
        end
      end
      SETUP: begin
        if (w_cull) begin
          w_setup_cull = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_setup_go   = 1'b1;
          w_next_state = SCAN;
        end
      end
      SCAN: begin
        if (bus.pix_ready) begin
          if (r_pix_x < r_max_x)      w_x_step     = 1'b1;
          else if (r_pix_y < r_max_y) w_y_step     = 1'b1;
          else                        w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Latch the offered triangle; attributes only ever change here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix_v0x       <= '0;
      r_pix_v0y       <= '0;
      r_v1x           <= '0;
      r_v1y           <= '0;
      r_v2x           <= '0;
      r_v2y           <= '0;
      r_pix_denom_inv <= '0;
      r_pix_c0        <= '0;
      r_pix_c1        <= '0;
      r_pix_c2        <= '0;
      r_pix_d0        <= '0;
      r_pix_d1        <= '0;
      r_pix_d2        <= '0;
    end else if (w_accept) begin
      r_pix_v0x       <= bus.tri_v0x;
      r_pix_v0y       <= bus.tri_v0y;
      r_v1x           <= bus.tri_v1x;
      r_v1y           <= bus.tri_v1y;
      r_v2x           <= bus.tri_v2x;
      r_v2y           <= bus.tri_v2y;
      r_pix_denom_inv <= bus.tri_denom_inv;
      r_pix_c0        <= bus.tri_c0;
      r_pix_c1        <= bus.tri_c1;
      r_pix_c2        <= bus.tri_c2;
      r_pix_d0        <= bus.tri_d0;
      r_pix_d1        <= bus.tri_d1;
      r_pix_d2        <= bus.tri_d2;
    end
  end

  // Edge vectors at CW bits; wraparound is acceptable because upstream bounds the range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix_e0x <= '0;
      r_pix_e0y <= '0;
      r_pix_e1x <= '0;
      r_pix_e1y <= '0;
    end else if (r_state == SETUP) begin
      r_pix_e0x <= r_v1x - r_pix_v0x;
      r_pix_e0y <= r_v1y - r_pix_v0y;
      r_pix_e1x <= r_v2x - r_pix_v0x;
      r_pix_e1y <= r_v2y - r_pix_v0y;
    end
  end

  // Scan position: load box origin after set-up, then walk x fastest on each handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix_x <= '0;
      r_pix_y <= '0;
      r_min_x <= '0;
      r_max_x <= '0;
      r_max_y <= '0;
    end else if (w_setup_go) begin
      r_pix_x <= w_min_x;
      r_pix_y <= w_min_y;
      r_min_x <= w_min_x;
      r_max_x <= w_max_x;
      r_max_y <= w_max_y;
    end else if (w_x_step) begin
      r_pix_x <= r_pix_x + 1'b1;
    end else if (w_y_step) begin
      r_pix_x <= r_min_x;
      r_pix_y <= r_pix_y + 1'b1;
    end
  end

  // One-cycle cull pulse, coincident with the return to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tri_culled <= 1'b0;
    else     r_tri_culled <= w_setup_cull;
  end

  assign bus.tri_ready     = (r_state == IDLE) && !rst;
  assign bus.pix_valid     = (r_state == SCAN);
  assign bus.tri_culled    = r_tri_culled;
  assign bus.busy          = (r_state != IDLE) || bus.eval_busy;

  assign bus.pix_x         = r_pix_x;
  assign bus.pix_y         = r_pix_y;
  assign bus.pix_v0x       = r_pix_v0x;
  assign bus.pix_v0y       = r_pix_v0y;
  assign bus.pix_e0x       = r_pix_e0x;
  assign bus.pix_e0y       = r_pix_e0y;
  assign bus.pix_e1x       = r_pix_e1x;
  assign bus.pix_e1y       = r_pix_e1y;
  assign bus.pix_denom_inv = r_pix_denom_inv;
  assign bus.pix_c0        = r_pix_c0;
  assign bus.pix_c1        = r_pix_c1;
  assign bus.pix_c2        = r_pix_c2;
  assign bus.pix_d0        = r_pix_d0;
  assign bus.pix_d1        = r_pix_d1;
  assign bus.pix_d2        = r_pix_d2;
endmodule
